bitwise_seq_unit: RTL and testbench



---
 rtl/bitwise_seq_pkg.sv | 33 +++
 rtl/bitwise_seq_unit_core.sv | 21 ++
 rtl/bitwise_seq_unit.sv | 113 +++++++++++
 tb/tb_bitwise_seq_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bitwise_seq_pkg.sv
// Shared definitions for the bitwise sequential unit: operation codes and
// the single-bit operation helper used by the combinational core.
package bitwise_seq_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_XOR    = 3'd0,
        OP_OR     = 3'd1,
        OP_AND    = 3'd2,
        OP_NOT_A  = 3'd3,
        OP_NAND   = 3'd4,
        OP_NOR    = 3'd5,
        OP_XNOR   = 3'd6,
        OP_PASS_B = 3'd7
    } op_e;

    function automatic logic op_bit(input logic a, input logic b, input op_e op);
        logic z;
        case (op)
            OP_XOR:    z = a ^ b;
            OP_OR:     z = a | b;
            OP_AND:    z = a & b;
            OP_NOT_A:  z = ~a;
            OP_NAND:   z = ~(a & b);
            OP_NOR:    z = ~(a | b);
            OP_XNOR:   z = ~(a ^ b);
            default:   z = b;
        endcase
        return z;
    endfunction

endpackage

// File: rtl/bitwise_seq_unit_core.sv
// Combinational bitwise operation block: every result bit depends only on
// the matching operand bits, so it is built as one slice per bit.
import bitwise_seq_pkg::*;

module bitwise_op_core #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] z
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign z[gi] = op_bit(a[gi], b[gi], op);
        end
    endgenerate

endmodule

// File: rtl/bitwise_seq_unit.sv
// Two-stage valid/ready bitwise logic unit with accumulator feedback and
// saturating tracking of result changes.
import bitwise_seq_pkg::*;

module bitwise_seq_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OP_W-1:0]  in_op,
    input  logic             in_acc,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_z,
    output logic             out_changed,
    output logic [WIDTH-1:0] acc_q,
    output logic [CNT_W-1:0] change_cnt
);

    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_a_reg;
    logic [WIDTH-1:0] s1_b_reg;
    op_e              s1_op_reg;
    logic             s1_acc_reg;

    logic             out_valid_reg;
    logic             out_changed_reg;
    logic [WIDTH-1:0] out_z_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] prev_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic             advance;
    logic             accept;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] result;

    assign advance  = s1_valid_reg && (!out_valid_reg || out_ready);
    assign in_ready = !s1_valid_reg || advance;
    assign accept   = in_valid && in_ready;

    // acc_reg always holds the result of the transaction just ahead, since
    // results load strictly in order.
    assign op_a = s1_acc_reg ? acc_reg : s1_a_reg;

    bitwise_op_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a  (op_a),
        .b  (s1_b_reg),
        .op (s1_op_reg),
        .z  (result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_op_reg    <= OP_XOR;
            s1_acc_reg   <= 1'b0;
        end else if (accept) begin
            s1_valid_reg <= 1'b1;
            s1_a_reg     <= in_a;
            s1_b_reg     <= in_b;
            s1_op_reg    <= op_e'(in_op);
            s1_acc_reg   <= in_acc;
        end else if (advance) begin
            s1_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg   <= 1'b0;
            out_changed_reg <= 1'b0;
            out_z_reg       <= '0;
            acc_reg         <= '0;
            prev_reg        <= '0;
            cnt_reg         <= '0;
        end else if (advance) begin
            // A coincident acc_clr is dropped: the fresh result wins.
            out_valid_reg   <= 1'b1;
            out_z_reg       <= result;
            out_changed_reg <= (result != prev_reg);
            prev_reg        <= result;
            acc_reg         <= result;
            if ((result != prev_reg) && (cnt_reg != {CNT_W{1'b1}})) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end else begin
            if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
            if (acc_clr) begin
                acc_reg <= '0;
            end
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_z       = out_z_reg;
    assign out_changed = out_changed_reg;
    assign acc_q       = acc_reg;
    assign change_cnt  = cnt_reg;

endmodule

// File: tb/tb_bitwise_seq_unit.sv
// Directed bench for bitwise_seq_unit: a transaction-queue model is compared
// against the DUT every cycle, with literal expectations pinning key points.
module tb_bitwise_seq_unit;

    localparam int WIDTH   = 8;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             in_acc;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_z;
    logic             out_changed;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] change_cnt;

    bitwise_seq_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_op       (in_op),
        .in_acc      (in_acc),
        .acc_clr     (acc_clr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_z       (out_z),
        .out_changed (out_changed),
        .acc_q       (acc_q),
        .change_cnt  (change_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic       acc;
    } txn_t;

    int         total = 0;
    int         bad = 0;
    txn_t       pend[$];
    logic [7:0] got[$];
    logic       m_ov;
    logic [7:0] m_z;
    logic       m_ch;
    logic [7:0] m_acc;
    logic [7:0] m_prev;
    int         m_cnt;
    logic       m_last_acc;

    function automatic logic [7:0] ref_op(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
        case (op)
            3'd0:    return a ^ b;
            3'd1:    return a | b;
            3'd2:    return a & b;
            3'd3:    return ~a;
            3'd4:    return ~(a & b);
            3'd5:    return ~(a | b);
            3'd6:    return ~(a ^ b);
            default: return b;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        m_ov = 1'b0; m_z = '0; m_ch = 1'b0;
        m_acc = '0; m_prev = '0; m_cnt = 0;
    endtask

    // Compare at the falling edge, then advance the model by one clock.
    task automatic tick();
        logic       exp_rdy;
        logic       adv;
        txn_t       t;
        logic [7:0] av;
        logic [7:0] r;
        @(negedge clk);
        exp_rdy = (pend.size() == 0) || !m_ov || out_ready;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("out_z", 32'(out_z), 32'(m_z));
        chk("out_changed", 32'(out_changed), 32'(m_ch));
        chk("acc_q", 32'(acc_q), 32'(m_acc));
        chk("change_cnt", 32'(change_cnt), 32'(m_cnt));
        m_last_acc = 1'b0;
        if (rst_n) begin
            adv = (pend.size() > 0) && (!m_ov || out_ready);
            if (adv) begin
                t  = pend.pop_front();
                av = t.acc ? m_acc : t.a;
                r  = ref_op(av, t.b, t.op);
                m_ch = (r != m_prev);
                if (m_ch && m_cnt < CNT_MAX) m_cnt++;
                m_prev = r; m_acc = r; m_z = r; m_ov = 1'b1;
                got.push_back(r);
                $display("txn result: op=%0d a=%02h b=%02h z=%02h changed=%0b cnt=%0d",
                         t.op, av, t.b, r, m_ch, m_cnt);
            end else begin
                if (m_ov && out_ready) m_ov = 1'b0;
                if (acc_clr) m_acc = '0;
            end
            if (in_valid && exp_rdy) begin
                pend.push_back('{a: in_a, b: in_b, op: in_op, acc: in_acc});
                m_last_acc = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic acc);
        in_valid = v; in_a = a; in_b = b; in_op = op; in_acc = acc;
    endtask

    logic [7:0] sweep_tbl[8];
    txn_t       bp_tbl[3];
    int         sat_tbl[5];
    int         idx;

    initial begin
        sweep_tbl = '{8'h99, 8'hBD, 8'h24, 8'h5A, 8'hDB, 8'h42, 8'h66, 8'h3C};
        bp_tbl    = '{'{8'h11, 8'h22, 3'd0, 1'b0}, '{8'h33, 8'h44, 3'd1, 1'b0},
                      '{8'h55, 8'h0F, 3'd2, 1'b0}};
        sat_tbl   = '{1, 2, 3, 3, 3};
        rst_n = 1'b0; out_ready = 1'b1; acc_clr = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
        model_reset();

        // Reset values
        tick(); tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_cnt", 32'(change_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic ops with accumulator chaining
        drive(1'b1, 8'h00, 8'hFF, 3'd0, 1'b0); tick();
        drive(1'b1, 8'h00, 8'h00, 3'd1, 1'b1); tick();
        chk("basic1_z", 32'(out_z), 32'hFF);
        chk("basic1_ch", 32'(out_changed), 32'd1);
        chk("basic1_cnt", 32'(change_cnt), 32'd1);
        drive(1'b1, 8'h00, 8'h00, 3'd3, 1'b1); tick();
        chk("basic2_z", 32'(out_z), 32'hFF);
        chk("basic2_ch", 32'(out_changed), 32'd0);
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0); tick();
        chk("basic3_z", 32'(out_z), 32'h00);
        chk("basic3_ch", 32'(out_changed), 32'd1);
        chk("basic3_cnt", 32'(change_cnt), 32'd2);
        tick();

        // Full op sweep, one result per cycle
        got.delete();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'hA5, 8'h3C, 3'(i), 1'b0);
            tick();
            if (i > 0) chk("sweep_z", 32'(out_z), 32'(sweep_tbl[i-1]));
        end
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0); tick();
        chk("sweep_last", 32'(out_z), 32'(sweep_tbl[7]));
        chk("sweep_count", 32'(got.size()), 32'd8);
        for (int i = 0; i < 8 && i < got.size(); i++) chk("sweep_model", 32'(got[i]), 32'(sweep_tbl[i]));
        tick();

        // Backpressure: consumer stalled for three cycles
        got.delete();
        idx = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            out_ready = (cyc >= 3);
            if (idx < 3) drive(1'b1, bp_tbl[idx].a, bp_tbl[idx].b, bp_tbl[idx].op, 1'b0);
            else drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
            tick();
            if (m_last_acc) idx++;
            if (cyc == 1 || cyc == 2) begin
                chk("bp_hold_z", 32'(out_z), 32'h33);
                chk("bp_hold_valid", 32'(out_valid), 32'd1);
            end
            if (cyc == 2) begin
                chk("bp_in_ready", 32'(in_ready), 32'd0);
                chk("bp_accepted", 32'(idx), 32'd2);
            end
        end
        chk("bp_total", 32'(idx), 32'd3);
        chk("bp_results", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            chk("bp_r0", 32'(got[0]), 32'h33);
            chk("bp_r1", 32'(got[1]), 32'h77);
            chk("bp_r2", 32'(got[2]), 32'h05);
        end

        // Accumulator clear, alone and coincident with an advance
        drive(1'b1, 8'h00, 8'h0F, 3'd7, 1'b0); tick();
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0); tick(); tick();
        chk("acc_loaded", 32'(acc_q), 32'h0F);
        acc_clr = 1'b1; tick(); acc_clr = 1'b0;
        chk("acc_cleared", 32'(acc_q), 32'h00);
        drive(1'b1, 8'h00, 8'h0F, 3'd7, 1'b0); tick();
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0); tick(); tick();
        drive(1'b1, 8'h00, 8'hF0, 3'd0, 1'b1); tick();
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0); acc_clr = 1'b1; tick(); acc_clr = 1'b0;
        chk("clr_adv_z", 32'(out_z), 32'hFF);
        chk("clr_adv_acc", 32'(acc_q), 32'hFF);
        tick();

        // Reset with two transactions in flight
        out_ready = 1'b0;
        drive(1'b1, 8'h01, 8'h02, 3'd0, 1'b0); tick();
        drive(1'b1, 8'h03, 8'h04, 3'd1, 1'b0); tick();
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd1);
        chk("midrst_z", 32'(out_z), 32'd0);
        model_reset();
        tick();
        rst_n = 1'b1; out_ready = 1'b1;
        tick(); tick();
        chk("midrst_no_stale", 32'(out_valid), 32'd0);

        // Counter saturation at 2^CNT_W-1
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'h00, (i % 2 == 0) ? 8'hFF : 8'h00, 3'd7, 1'b0);
            tick();
            if (i > 0) chk("sat_cnt", 32'(change_cnt), 32'(sat_tbl[i-1]));
        end
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0); tick();
        chk("sat_cnt_last", 32'(change_cnt), 32'(sat_tbl[4]));
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
